// File: rtl/load_data_aligner.sv
// load_data_aligner: read-return byte-lane aligner for data-memory loads.
// Queues {offset,size,sign} of each issued load, pairs it in order with the
// memory return, byte-swaps the bus word, extracts byte/half/word and extends.
// Ports: iCLOCK/inRESET (async, active low)/iRESET_SYNC (sync clear);
//   request side iREQ_VALID/iREQ_ADDR/iREQ_SIZE/iREQ_SIGNED, oREQ_LOCK when full;
//   memory side iMEM_VALID/iMEM_DATA, oMEM_BUSY back-pressure;
//   writeback side oDATA_VALID/oDATA, iDATA_BUSY stall.
// Option LOAD_ALIGNER_ERR_CHECK_EN adds oDATA_ERR (misaligned/invalid size,
// or a return that arrived with no load pending).
module load_data_aligner #(
   parameter int P_DEPTH   = 4,
   parameter int P_DEPTH_N = 2
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iRESET_SYNC,
   input  logic        iREQ_VALID,
   output logic        oREQ_LOCK,
   input  logic [1:0]  iREQ_ADDR,
   input  logic [1:0]  iREQ_SIZE,
   input  logic        iREQ_SIGNED,
   input  logic        iMEM_VALID,
   output logic        oMEM_BUSY,
   input  logic [31:0] iMEM_DATA,
   output logic        oDATA_VALID,
   input  logic        iDATA_BUSY,
   output logic [31:0] oDATA
`ifdef LOAD_ALIGNER_ERR_CHECK_EN
   ,
   output logic        oDATA_ERR
`endif
);
   logic [4:0]           r_fifo [P_DEPTH];
   logic [P_DEPTH_N-1:0] r_wr_ptr;
   logic [P_DEPTH_N-1:0] r_rd_ptr;
   logic [P_DEPTH_N:0]   r_count;
   logic                 r_valid;
   logic [31:0]          r_data;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_nonempty;
   logic                 w_load;
   logic [1:0]           w_addr;
   logic [1:0]           w_size;
   logic                 w_signed;
   logic [31:0]          w_swap;
   logic [7:0]           w_byte;
   logic [15:0]          w_half;
   logic [31:0]          w_result;
   logic [31:0]          w_load_data;
   // Head entry: the oldest outstanding load; a same-cycle push never lands here while empty.
   assign {w_addr, w_size, w_signed} = r_fifo[r_rd_ptr];
   assign oREQ_LOCK   = r_count == (P_DEPTH_N + 1)'(P_DEPTH);
   assign oMEM_BUSY   = r_valid && iDATA_BUSY;
   assign oDATA_VALID = r_valid;
   assign oDATA       = r_data;
   assign w_nonempty  = r_count != '0;
   assign w_push      = iREQ_VALID && !oREQ_LOCK;
   assign w_pop       = iMEM_VALID && !oMEM_BUSY && w_nonempty;
   assign w_swap      = {iMEM_DATA[7:0], iMEM_DATA[15:8], iMEM_DATA[23:16], iMEM_DATA[31:24]};
   assign w_byte      = 8'(w_swap >> {w_addr, 3'b000});
   assign w_half      = 16'(w_swap >> {w_addr[1], 4'b0000});
   // Size 3 falls through to word.
   always_comb
      w_result = (w_size == 2'd0) ? {{24{w_signed & w_byte[7]}}, w_byte} :
                 (w_size == 2'd1) ? {{16{w_signed & w_half[15]}}, w_half} : w_swap;
`ifdef LOAD_ALIGNER_ERR_CHECK_EN
   logic w_err;
   logic r_err;
   assign w_err = (w_size == 2'd1 && w_addr[0]) || (w_size == 2'd2 && w_addr != 2'd0) || w_size == 2'd3;
   // An unmatched return still produces a flagged, zero result.
   assign w_load      = iMEM_VALID && !oMEM_BUSY;
   assign w_load_data = w_nonempty ? w_result : 32'h0;
   assign oDATA_ERR   = r_err;
   always_ff @(posedge iCLOCK or negedge inRESET)
      if (!inRESET)
         r_err <= 1'b0;
      else if (iRESET_SYNC)
         r_err <= 1'b0;
      else if (w_load)
         r_err <= !w_nonempty || w_err;
`else
   assign w_load      = w_pop;
   assign w_load_data = w_result;
`endif
   always_ff @(posedge iCLOCK)
      if (w_push)
         r_fifo[r_wr_ptr] <= {iREQ_ADDR, iREQ_SIZE, iREQ_SIGNED};
   always_ff @(posedge iCLOCK or negedge inRESET)
      if (!inRESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_data   <= 32'h0;
      end else if (iRESET_SYNC) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_data   <= 32'h0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (P_DEPTH_N + 1)'(w_push) - (P_DEPTH_N + 1)'(w_pop);
         if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_load_data;
         end else if (!iDATA_BUSY)
            r_valid <= 1'b0;
      end
endmodule

// File: tb/tb_load_data_aligner.sv
// tb_load_data_aligner: randomized + directed bench with a queue-based reference model.
module tb_load_data_aligner;
   logic        iCLOCK = 1'b0;
   logic        inRESET = 1'b0;
   logic        iRESET_SYNC = 1'b0;
   logic        iREQ_VALID = 1'b0;
   logic        oREQ_LOCK;
   logic [1:0]  iREQ_ADDR = '0;
   logic [1:0]  iREQ_SIZE = '0;
   logic        iREQ_SIGNED = 1'b0;
   logic        iMEM_VALID = 1'b0;
   logic        oMEM_BUSY;
   logic [31:0] iMEM_DATA = '0;
   logic        oDATA_VALID;
   logic        iDATA_BUSY = 1'b0;
   logic [31:0] oDATA;
`ifdef LOAD_ALIGNER_ERR_CHECK_EN
   logic        oDATA_ERR;
   logic        exp_err;
`endif

   load_data_aligner dut (
      .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
      .iREQ_VALID(iREQ_VALID), .oREQ_LOCK(oREQ_LOCK), .iREQ_ADDR(iREQ_ADDR),
      .iREQ_SIZE(iREQ_SIZE), .iREQ_SIGNED(iREQ_SIGNED), .iMEM_VALID(iMEM_VALID),
      .oMEM_BUSY(oMEM_BUSY), .iMEM_DATA(iMEM_DATA), .oDATA_VALID(oDATA_VALID),
      .iDATA_BUSY(iDATA_BUSY), .oDATA(oDATA)
`ifdef LOAD_ALIGNER_ERR_CHECK_EN
      , .oDATA_ERR(oDATA_ERR)
`endif
   );

   always #5 iCLOCK = ~iCLOCK;

   typedef struct {logic [1:0] a; logic [1:0] sz; logic sg;} attr_t;
   attr_t       q[$];
   logic        exp_valid;
   logic [31:0] exp_data;
   int          checks = 0;
   int          failures = 0;

   // Memory byte at CPU offset k is bus byte 3-k; assemble the load from those bytes.
   function automatic logic [31:0] align(input logic [31:0] d, input attr_t t);
      logic [7:0]  mb [4];
      logic [31:0] v;
      int          base;
      for (int k = 0; k < 4; k++) mb[k] = d[8*(3-k) +: 8];
      if (t.sz == 2'd0) begin
         v = {24'h0, mb[t.a]};
         if (t.sg && v[7]) v = v | 32'hFFFFFF00;
      end else if (t.sz == 2'd1) begin
         base = t.a[1] ? 2 : 0;
         v = {16'h0, mb[base+1], mb[base]};
         if (t.sg && v[15]) v = v | 32'hFFFF0000;
      end else
         v = {mb[3], mb[2], mb[1], mb[0]};
      return v;
   endfunction

`ifdef LOAD_ALIGNER_ERR_CHECK_EN
   function automatic logic errf(input attr_t t);
      return (t.sz == 2'd1 && t.a[0]) || (t.sz == 2'd2 && t.a != 2'd0) || t.sz == 2'd3;
   endfunction
`endif

   task automatic model_clear();
      q.delete();
      exp_valid = 1'b0;
      exp_data  = 32'h0;
`ifdef LOAD_ALIGNER_ERR_CHECK_EN
      exp_err   = 1'b0;
`endif
   endtask

   // Advance the model with the inputs present at the coming edge, then clock the DUT.
   task automatic tick();
      logic  busy;
      logic  lock;
      attr_t t;
      busy = exp_valid && iDATA_BUSY;
      lock = q.size() == 4;
      if (iRESET_SYNC)
         model_clear();
      else begin
         if (iMEM_VALID && !busy && q.size() > 0) begin
            t = q.pop_front();
            exp_data  = align(iMEM_DATA, t);
            exp_valid = 1'b1;
`ifdef LOAD_ALIGNER_ERR_CHECK_EN
            exp_err   = errf(t);
         end else if (iMEM_VALID && !busy) begin
            exp_data  = 32'h0;
            exp_valid = 1'b1;
            exp_err   = 1'b1;
`endif
         end else if (!iDATA_BUSY)
            exp_valid = 1'b0;
         if (iREQ_VALID && !lock) q.push_back('{iREQ_ADDR, iREQ_SIZE, iREQ_SIGNED});
      end
      @(posedge iCLOCK);
      #1;
   endtask

   task automatic idle_inputs();
      iREQ_VALID = 1'b0;
      iMEM_VALID = 1'b0;
      iDATA_BUSY = 1'b0;
      iRESET_SYNC = 1'b0;
   endtask

   task automatic push_rand();
      iREQ_VALID  = 1'b1;
      iREQ_ADDR   = 2'($urandom_range(0, 3));
      iREQ_SIZE   = 2'($urandom_range(0, 3));
      iREQ_SIGNED = 1'($urandom_range(0, 1));
   endtask

   task automatic test_reset();
      @(posedge iCLOCK);
      #1;
      model_clear();
      checks++; if (oDATA_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", oDATA_VALID); end
      checks++; if (oDATA !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", oDATA); end
      checks++; if (oREQ_LOCK !== 1'b0) begin failures++; $display("FAIL reset_lock got=%b exp=0", oREQ_LOCK); end
      checks++; if (oMEM_BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", oMEM_BUSY); end
`ifdef LOAD_ALIGNER_ERR_CHECK_EN
      checks++; if (oDATA_ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", oDATA_ERR); end
`endif
      inRESET = 1'b1;
      tick();
   endtask

   task automatic test_vectors();
      logic [31:0] d  [7] = '{32'h11223344, 32'h11223344, 32'h11223344, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
      logic [1:0]  a  [7] = '{2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3};
      logic [1:0]  sz [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
      logic        sg [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] ex [7] = '{32'h00000011, 32'h00000044, 32'h44332211, 32'hFFFFFF80, 32'hFFFFFF80, 32'h0000017F, 32'h00000001};
      for (int i = 0; i < 7; i++) begin
         iREQ_VALID = 1'b1; iREQ_ADDR = a[i]; iREQ_SIZE = sz[i]; iREQ_SIGNED = sg[i];
         tick();
         iREQ_VALID = 1'b0; iMEM_VALID = 1'b1; iMEM_DATA = d[i];
         checks++; if (oDATA_VALID !== 1'b0) begin failures++; $display("FAIL vec%0d_latency got=%b exp=0", i, oDATA_VALID); end
         tick();
         iMEM_VALID = 1'b0;
         checks++; if (oDATA_VALID !== 1'b1) begin failures++; $display("FAIL vec%0d_valid got=%b exp=1", i, oDATA_VALID); end
         checks++; if (oDATA !== ex[i]) begin failures++; $display("FAIL vec%0d_data got=%h exp=%h", i, oDATA, ex[i]); end
         tick();
         checks++; if (oDATA_VALID !== 1'b0) begin failures++; $display("FAIL vec%0d_clear got=%b exp=0", i, oDATA_VALID); end
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 5; i++) begin
         push_rand();
         #1;
         checks++; if (oREQ_LOCK !== (i == 4)) begin failures++; $display("FAIL full_lock%0d got=%b exp=%b", i, oREQ_LOCK, i == 4); end
         tick();
      end
      iREQ_VALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         iMEM_VALID = 1'b1; iMEM_DATA = $urandom;
         tick();
         checks++; if (oDATA_VALID !== 1'b1) begin failures++; $display("FAIL full_ret%0d_valid got=%b exp=1", i, oDATA_VALID); end
         checks++; if (oDATA !== exp_data) begin failures++; $display("FAIL full_ret%0d_data got=%h exp=%h", i, oDATA, exp_data); end
         checks++; if (oREQ_LOCK !== 1'b0) begin failures++; $display("FAIL full_ret%0d_lock got=%b exp=0", i, oREQ_LOCK); end
      end
      iMEM_DATA = $urandom;
      tick();
      iMEM_VALID = 1'b0;
      checks++; if (oDATA_VALID !== exp_valid) begin failures++; $display("FAIL full_extra_valid got=%b exp=%b", oDATA_VALID, exp_valid); end
      checks++; if (oDATA !== exp_data) begin failures++; $display("FAIL full_extra_data got=%h exp=%h", oDATA, exp_data); end
      tick();
   endtask

   task automatic test_hold();
      logic [31:0] held;
      push_rand();
      tick();
      push_rand();
      iMEM_VALID = 1'b1; iMEM_DATA = $urandom;
      tick();
      held = exp_data;
      iREQ_VALID = 1'b0; iDATA_BUSY = 1'b1; iMEM_DATA = $urandom;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (oMEM_BUSY !== 1'b1) begin failures++; $display("FAIL hold%0d_busy got=%b exp=1", i, oMEM_BUSY); end
         tick();
         checks++; if (oDATA_VALID !== 1'b1 || oDATA !== held) begin failures++; $display("FAIL hold%0d_data got=%b/%h exp=1/%h", i, oDATA_VALID, oDATA, held); end
      end
      iDATA_BUSY = 1'b0;
      tick();
      iMEM_VALID = 1'b0;
      checks++; if (oDATA_VALID !== 1'b1 || oDATA !== exp_data) begin failures++; $display("FAIL hold_release got=%b/%h exp=1/%h", oDATA_VALID, oDATA, exp_data); end
      tick();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin push_rand(); tick(); end
      iREQ_VALID = 1'b0; iMEM_VALID = 1'b1; iMEM_DATA = $urandom;
      tick();
      iMEM_VALID = 1'b0; iDATA_BUSY = 1'b1;
      inRESET = 1'b0;
      #1;
      model_clear();
      checks++; if (oDATA_VALID !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", oDATA_VALID); end
      checks++; if (oREQ_LOCK !== 1'b0) begin failures++; $display("FAIL areset_lock got=%b exp=0", oREQ_LOCK); end
      #2;
      inRESET = 1'b1; iDATA_BUSY = 1'b0;
      iMEM_VALID = 1'b1; iMEM_DATA = $urandom;
      tick();
      iMEM_VALID = 1'b0;
      checks++; if (oDATA_VALID !== exp_valid || oDATA !== exp_data) begin failures++; $display("FAIL areset_drop got=%b/%h exp=%b/%h", oDATA_VALID, oDATA, exp_valid, exp_data); end
      tick();
   endtask

   task automatic test_sync_reset();
      for (int i = 0; i < 2; i++) begin push_rand(); tick(); end
      iREQ_VALID = 1'b0; iMEM_VALID = 1'b1; iMEM_DATA = $urandom;
      tick();
      push_rand(); iRESET_SYNC = 1'b1;
      tick();
      iRESET_SYNC = 1'b0; iREQ_VALID = 1'b0;
      checks++; if (oDATA_VALID !== 1'b0 || oDATA !== 32'h0 || oREQ_LOCK !== 1'b0) begin failures++; $display("FAIL sreset got=%b/%h/%b exp=0/00000000/0", oDATA_VALID, oDATA, oREQ_LOCK); end
      iMEM_DATA = $urandom;
      tick();
      iMEM_VALID = 1'b0;
      checks++; if (oDATA_VALID !== exp_valid || oDATA !== exp_data) begin failures++; $display("FAIL sreset_drop got=%b/%h exp=%b/%h", oDATA_VALID, oDATA, exp_valid, exp_data); end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         iREQ_VALID  = 1'($urandom_range(0, 1));
         iREQ_ADDR   = 2'($urandom_range(0, 3));
         iREQ_SIZE   = 2'($urandom_range(0, 3));
         iREQ_SIGNED = 1'($urandom_range(0, 1));
         iMEM_VALID  = ($urandom_range(0, 2) != 0);
         iMEM_DATA   = $urandom;
         iDATA_BUSY  = ($urandom_range(0, 3) == 0);
         iRESET_SYNC = ($urandom_range(0, 99) == 0);
         #1;
         checks++; if (oMEM_BUSY !== (exp_valid && iDATA_BUSY) || oREQ_LOCK !== (q.size() == 4)) begin failures++; $display("FAIL rand%0d_flow got=%b/%b exp=%b/%b", i, oMEM_BUSY, oREQ_LOCK, exp_valid && iDATA_BUSY, q.size() == 4); end
         tick();
         checks++; if (oDATA_VALID !== exp_valid || oDATA !== exp_data) begin failures++; $display("FAIL rand%0d_out got=%b/%h exp=%b/%h", i, oDATA_VALID, oDATA, exp_valid, exp_data); end
`ifdef LOAD_ALIGNER_ERR_CHECK_EN
         checks++; if (oDATA_ERR !== exp_err) begin failures++; $display("FAIL rand%0d_err got=%b exp=%b", i, oDATA_ERR, exp_err); end
`endif
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_vectors();
      test_full();
      test_hold();
      test_async_reset();
      test_sync_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
